// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_ctrl_pkg
// Purpose  : Shared types and encodings for the Simple RISC Machine control FSM
// Revision : 1.0  initial release
// ============================================================================
package cpu_ctrl_pkg;

    // Controller states
    typedef enum logic [4:0] {
        S_RST, S_FETCH, S_PC, S_DECODE, S_WIMM, S_GETA, S_GETB, S_EXEC,
        S_WRD, S_ADDR, S_LATCH, S_LDMEM, S_STB, S_STC, S_STMEM, S_HALT, S_ERR
    } state_t;

    // Instruction classes produced by the decoder
    typedef enum logic [2:0] {
        CL_MOVI, CL_MOVR, CL_ALU, CL_CMP, CL_LDR, CL_STR, CL_HALT, CL_ILLEGAL
    } iclass_t;

    // Instruction field bit positions
    localparam int c_OPC_HI = 15;
    localparam int c_OPC_LO = 13;
    localparam int c_OP_HI  = 12;
    localparam int c_OP_LO  = 11;
    localparam int c_RN_HI  = 10;
    localparam int c_RN_LO  = 8;
    localparam int c_RD_HI  = 7;
    localparam int c_RD_LO  = 5;
    localparam int c_SH_HI  = 4;
    localparam int c_SH_LO  = 3;
    localparam int c_RM_HI  = 2;
    localparam int c_RM_LO  = 0;

    // Opcode values
    localparam logic [2:0] c_OPC_MOV  = 3'b110;
    localparam logic [2:0] c_OPC_ALU  = 3'b101;
    localparam logic [2:0] c_OPC_LDR  = 3'b011;
    localparam logic [2:0] c_OPC_STR  = 3'b100;
    localparam logic [2:0] c_OPC_HALT = 3'b111;

    // Op sub-field values
    localparam logic [1:0] c_OP_MOVI = 2'b10;
    localparam logic [1:0] c_OP_MOVR = 2'b00;
    localparam logic [1:0] c_OP_CMP  = 2'b01;
    localparam logic [1:0] c_OP_MVN  = 2'b11;
    localparam logic [1:0] c_OP_MEM  = 2'b00;

    // ALU operation encodings
    localparam logic [1:0] c_ALU_ADD = 2'b00;
    localparam logic [1:0] c_ALU_SUB = 2'b01;
    localparam logic [1:0] c_ALU_AND = 2'b10;
    localparam logic [1:0] c_ALU_NOT = 2'b11;

    // Shifter encodings
    localparam logic [1:0] c_SH_NONE = 2'b00;
    localparam logic [1:0] c_SH_LSL  = 2'b01;
    localparam logic [1:0] c_SH_LSR  = 2'b10;
    localparam logic [1:0] c_SH_ASR  = 2'b11;

    // Writeback source encodings
    localparam logic [1:0] c_WB_C     = 2'b00;
    localparam logic [1:0] c_WB_PC    = 2'b01;
    localparam logic [1:0] c_WB_IMM8  = 2'b10;
    localparam logic [1:0] c_WB_MDATA = 2'b11;

endpackage
`default_nettype wire

// File: rtl/cpu_controller_instr_decoder.sv
`default_nettype none
// ============================================================================
// Module   : instr_decoder
// Purpose  : Splits the instruction register into fields and classifies it
// Revision : 1.0  initial release
// ============================================================================
module instr_decoder
    import cpu_ctrl_pkg::*;
(
    input  logic [15:0] i_instr,
    output logic [1:0]  o_op,
    output logic [2:0]  o_rn,
    output logic [2:0]  o_rd,
    output logic [1:0]  o_sh,
    output logic [2:0]  o_rm,
    output iclass_t     o_class
);

    logic [2:0] w_opc;

    assign w_opc = i_instr[c_OPC_HI:c_OPC_LO];
    assign o_op  = i_instr[c_OP_HI:c_OP_LO];
    assign o_rn  = i_instr[c_RN_HI:c_RN_LO];
    assign o_rd  = i_instr[c_RD_HI:c_RD_LO];
    assign o_sh  = i_instr[c_SH_HI:c_SH_LO];
    assign o_rm  = i_instr[c_RM_HI:c_RM_LO];

    // Classify opcode/op pairs; any unlisted combination is illegal
    always_comb begin
        o_class = CL_ILLEGAL;
        case (w_opc)
            c_OPC_MOV: begin
                if (o_op == c_OP_MOVI)      o_class = CL_MOVI;
                else if (o_op == c_OP_MOVR) o_class = CL_MOVR;
            end
            c_OPC_ALU:  o_class = (o_op == c_OP_CMP) ? CL_CMP : CL_ALU;
            c_OPC_LDR:  if (o_op == c_OP_MEM) o_class = CL_LDR;
            c_OPC_STR:  if (o_op == c_OP_MEM) o_class = CL_STR;
            c_OPC_HALT: o_class = CL_HALT;
            default:    o_class = CL_ILLEGAL;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/cpu_controller.sv
`default_nettype none
// ============================================================================
// Module   : cpu_controller
// Purpose  : Multi-cycle fetch/decode/execute control FSM for the 16-bit
//            Simple RISC Machine datapath, with req/ack memory handshake
// Revision : 1.0  initial release
// ============================================================================
module cpu_controller
    import cpu_ctrl_pkg::*;
#(
    parameter int ACK_TIMEOUT = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] instr,
    input  logic        mem_ack,
    output logic        load_ir,
    output logic        load_pc,
    output logic        clear_pc,
    output logic        addr_sel,
    output logic        load_addr,
    output logic        mem_req,
    output logic        mem_we,
    output logic [2:0]  r_addr,
    output logic [2:0]  w_addr,
    output logic        w_en,
    output logic        en_A,
    output logic        en_B,
    output logic        en_C,
    output logic        en_status,
    output logic        sel_A,
    output logic        sel_B,
    output logic [1:0]  ALU_op,
    output logic [1:0]  shift_op,
    output logic [1:0]  wb_sel,
    output logic        halted,
    output logic        err
);

    // Last counter value at which one more unacknowledged cycle means timeout
    localparam logic [15:0] c_TO_LAST = (ACK_TIMEOUT > 0) ? 16'(ACK_TIMEOUT - 1) : 16'd0;

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_wait;
    logic        w_timeout;
    logic [1:0]  w_op;
    logic [2:0]  w_rn;
    logic [2:0]  w_rd;
    logic [1:0]  w_sh;
    logic [2:0]  w_rm;
    iclass_t     w_class;
    logic        w_is_mvn;

    instr_decoder u_dec (
        .i_instr (instr),
        .o_op    (w_op),
        .o_rn    (w_rn),
        .o_rd    (w_rd),
        .o_sh    (w_sh),
        .o_rm    (w_rm),
        .o_class (w_class)
    );

    assign w_is_mvn  = (w_class == CL_ALU) && (w_op == c_OP_MVN);
    assign w_timeout = (ACK_TIMEOUT != 0) && (r_wait == c_TO_LAST);

    // State register; reset abandons any transaction in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_RST;
        else        r_state <= w_next;
    end

    // Wait counter: cleared on every state change, counts unacknowledged requests
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  r_wait <= '0;
        else if (w_next != r_state)  r_wait <= '0;
        else if (mem_req && !mem_ack) r_wait <= r_wait + 16'd1;
    end

    // Next-state and Moore strobes (mem_ack only gates the acknowledge cycle)
    always_comb begin
        w_next    = r_state;
        load_ir   = 1'b0;
        load_pc   = 1'b0;
        clear_pc  = 1'b0;
        addr_sel  = 1'b0;
        load_addr = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        r_addr    = 3'd0;
        w_addr    = 3'd0;
        w_en      = 1'b0;
        en_A      = 1'b0;
        en_B      = 1'b0;
        en_C      = 1'b0;
        en_status = 1'b0;
        sel_A     = 1'b0;
        sel_B     = 1'b0;
        ALU_op    = c_ALU_ADD;
        shift_op  = c_SH_NONE;
        wb_sel    = c_WB_C;
        halted    = 1'b0;
        err       = 1'b0;
        case (r_state)
            S_RST: begin
                clear_pc = 1'b1;
                load_pc  = 1'b1;
                w_next   = S_FETCH;
            end
            S_FETCH: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                if (mem_ack) begin
                    load_ir = 1'b1;
                    w_next  = S_PC;
                end else if (w_timeout) begin
                    w_next = S_ERR;
                end
            end
            S_PC: begin
                load_pc = 1'b1;
                w_next  = S_DECODE;
            end
            S_DECODE: begin
                case (w_class)
                    CL_MOVI:                  w_next = S_WIMM;
                    CL_MOVR:                  w_next = S_GETB;
                    CL_ALU:                   w_next = w_is_mvn ? S_GETB : S_GETA;
                    CL_CMP, CL_LDR, CL_STR:   w_next = S_GETA;
                    CL_HALT:                  w_next = S_HALT;
                    default:                  w_next = S_ERR;
                endcase
            end
            S_WIMM: begin
                w_en   = 1'b1;
                w_addr = w_rn;
                wb_sel = c_WB_IMM8;
                w_next = S_FETCH;
            end
            S_GETA: begin
                r_addr = w_rn;
                en_A   = 1'b1;
                w_next = (w_class == CL_LDR || w_class == CL_STR) ? S_ADDR : S_GETB;
            end
            S_GETB: begin
                r_addr = w_rm;
                en_B   = 1'b1;
                w_next = S_EXEC;
            end
            S_EXEC: begin
                shift_op = w_sh;
                sel_A    = (w_class == CL_MOVR) || w_is_mvn;
                if (w_class == CL_CMP) begin
                    en_status = 1'b1;
                    ALU_op    = c_ALU_SUB;
                    w_next    = S_FETCH;
                end else begin
                    ALU_op = (w_class == CL_ALU) ? w_op : c_ALU_ADD;
                    en_C   = 1'b1;
                    w_next = S_WRD;
                end
            end
            S_WRD: begin
                w_en   = 1'b1;
                w_addr = w_rd;
                wb_sel = c_WB_C;
                w_next = S_FETCH;
            end
            S_ADDR: begin
                sel_B  = 1'b1;
                ALU_op = c_ALU_ADD;
                en_C   = 1'b1;
                w_next = S_LATCH;
            end
            S_LATCH: begin
                load_addr = 1'b1;
                w_next    = (w_class == CL_STR) ? S_STB : S_LDMEM;
            end
            S_LDMEM: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    w_en   = 1'b1;
                    w_addr = w_rd;
                    wb_sel = c_WB_MDATA;
                    w_next = S_FETCH;
                end else if (w_timeout) begin
                    w_next = S_ERR;
                end
            end
            S_STB: begin
                r_addr = w_rd;
                en_B   = 1'b1;
                w_next = S_STC;
            end
            S_STC: begin
                sel_A  = 1'b1;
                en_C   = 1'b1;
                w_next = S_STMEM;
            end
            S_STMEM: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                if (mem_ack)        w_next = S_FETCH;
                else if (w_timeout) w_next = S_ERR;
            end
            S_HALT:  halted = 1'b1;
            S_ERR:   err    = 1'b1;
            default: w_next = S_ERR;
        endcase
    end

endmodule
`default_nettype wire
